// File: rtl/fifo_serial_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_serial_drain
// Purpose  : Pulls words from a synchronous FIFO and sends each one as a
//            serial frame: start, data MSB-first, optional even parity, stop.
// Revision : 1.0  initial release
// ============================================================================
module fifo_serial_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  sink_ready,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out,
    input  logic                  FIFO_empty,
    output logic                  read_enable,
    output logic                  serial_out,
    output logic                  tx_busy,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frames_sent
);

    localparam int c_BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int c_BAUD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BIT_CYCLES - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_READ   = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_START  = 3'd3;
    localparam logic [2:0] c_DATA   = 3'd4;
    localparam logic [2:0] c_PARITY = 3'd5;
    localparam logic [2:0] c_STOP   = 3'd6;

    logic [2:0]            r_state;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_read_enable;
    logic                  r_serial_out;
    logic                  r_tx_busy;
    logic                  r_frame_done;
    logic [CNT_WIDTH-1:0]  r_frames_sent;

    logic [2:0]            w_state_nxt;
    logic [c_BAUD_W-1:0]   w_baud_nxt;
    logic [c_BIT_W-1:0]    w_bit_nxt;
    logic [c_BIT_W-1:0]    w_sel;
    logic                  w_baud_last;
    logic                  w_serial_nxt;
    logic                  w_done_nxt;

    assign w_baud_last = (r_baud == c_BAUD_LAST);

    // State register; outputs are registered from next-state values so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state       <= c_IDLE;
            r_baud        <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_read_enable <= 1'b0;
            r_serial_out  <= 1'b1;
            r_tx_busy     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_baud        <= w_baud_nxt;
            r_bit         <= w_bit_nxt;
            if (r_state == c_WAIT) begin
                r_shift  <= FIFO_data_out;
                r_parity <= ^FIFO_data_out;
            end
            r_read_enable <= (w_state_nxt == c_READ);
            r_serial_out  <= w_serial_nxt;
            r_tx_busy     <= (w_state_nxt != c_IDLE);
            r_frame_done  <= w_done_nxt;
            if (w_done_nxt) begin
                r_frames_sent <= r_frames_sent + 1'b1;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = '0;
        w_bit_nxt   = r_bit;
        case (r_state)
            c_IDLE: begin
                w_bit_nxt = '0;
                if (Enable && !FIFO_empty && sink_ready) begin
                    w_state_nxt = c_READ;
                end
            end
            c_READ:  w_state_nxt = c_WAIT;
            c_WAIT:  w_state_nxt = c_START;
            c_START: begin
                if (w_baud_last) begin
                    w_state_nxt = c_DATA;
                    w_bit_nxt   = '0;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            c_DATA: begin
                if (!w_baud_last) begin
                    w_baud_nxt = r_baud + 1'b1;
                end else if (r_bit == c_BIT_LAST) begin
                    w_state_nxt = (PARITY_EN != 0) ? c_PARITY : c_STOP;
                    w_bit_nxt   = '0;
                end else begin
                    w_bit_nxt = r_bit + 1'b1;
                end
            end
            c_PARITY: begin
                if (w_baud_last) begin
                    w_state_nxt = c_STOP;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            c_STOP: begin
                if (w_baud_last) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle
    always_comb begin
        w_sel        = c_BIT_LAST - w_bit_nxt;
        w_serial_nxt = 1'b1;
        w_done_nxt   = (r_state == c_STOP) && w_baud_last;
        case (w_state_nxt)
            c_START:  w_serial_nxt = 1'b0;
            c_DATA:   w_serial_nxt = r_shift[w_sel];
            c_PARITY: w_serial_nxt = r_parity;
            default:  w_serial_nxt = 1'b1;
        endcase
    end

    assign read_enable = r_read_enable;
    assign serial_out  = r_serial_out;
    assign tx_busy     = r_tx_busy;
    assign frame_done  = r_frame_done;
    assign frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_fifo_serial_drain.sv
`default_nettype none
// Bench for fifo_serial_drain: FIFO model feeding the DUT, directed frames
// checked bit-by-bit against hand-computed line values.
module tb_fifo_serial_drain;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b1;
    logic        sink_ready = 1'b1;
    logic [7:0]  FIFO_data_out = 8'h00;
    logic        FIFO_empty;
    logic        read_enable;
    logic        serial_out;
    logic        tx_busy;
    logic        frame_done;
    logic [15:0] frames_sent;

    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int re_cnt = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int last_done_cyc = 0;

    fifo_serial_drain #(
        .DATA_WIDTH (8),
        .BIT_CYCLES (2),
        .PARITY_EN  (1),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .Enable        (Enable),
        .sink_ready    (sink_ready),
        .FIFO_data_out (FIFO_data_out),
        .FIFO_empty    (FIFO_empty),
        .read_enable   (read_enable),
        .serial_out    (serial_out),
        .tx_busy       (tx_busy),
        .frame_done    (frame_done),
        .frames_sent   (frames_sent)
    );

    always #5 clk = ~clk;

    assign FIFO_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (read_enable) begin
            FIFO_data_out <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
            re_cnt        <= re_cnt + 1;
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        Enable = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    // Expects READ on the next cycle, then a full frame and the done pulse.
    task automatic run_frame(input logic [7:0] d, input logic par, input int drop_at, input string tag);
        logic exp [0:21];
        exp[0] = 1'b0;
        exp[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp[2 + 2*k] = d[7-k];
            exp[3 + 2*k] = d[7-k];
        end
        exp[18] = par;
        exp[19] = par;
        exp[20] = 1'b1;
        exp[21] = 1'b1;
        @(negedge clk);
        total++;
        if (read_enable !== 1'b1 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s read: read_enable=%b tx_busy=%b want 1 1", tag, read_enable, tx_busy);
        end
        @(negedge clk);
        total++;
        if (read_enable !== 1'b0 || serial_out !== 1'b1 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s wait: read_enable=%b serial_out=%b tx_busy=%b want 0 1 1",
                     tag, read_enable, serial_out, tx_busy);
        end
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            total++;
            if (serial_out !== exp[i] || read_enable !== 1'b0 || frame_done !== 1'b0 || tx_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s cyc%0d: serial_out=%b re=%b done=%b busy=%b want %b 0 0 1",
                         tag, i, serial_out, read_enable, frame_done, tx_busy, exp[i]);
            end
            if (i == drop_at) Enable = 1'b0;
        end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b1 || tx_busy !== 1'b0 || serial_out !== 1'b1) begin
            bad++;
            $display("FAIL %s done: frame_done=%b tx_busy=%b serial_out=%b want 1 0 1",
                     tag, frame_done, tx_busy, serial_out);
        end
        last_done_cyc = cyc;
    endtask

    task automatic test_reset();
        push(8'hAF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (read_enable !== 1'b0 || serial_out !== 1'b1 || tx_busy !== 1'b0 ||
                frame_done !== 1'b0 || frames_sent !== 16'd0) begin
                bad++;
                $display("FAIL reset%0d: re=%b so=%b busy=%b done=%b cnt=%0d want 0 1 0 0 0",
                         i, read_enable, serial_out, tx_busy, frame_done, frames_sent);
            end
        end
        Enable = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        Enable = 1'b1;
        run_frame(8'hAF, 1'b0, -1, "single_AF");
        total++;
        if (frames_sent !== 16'd1) begin
            bad++;
            $display("FAIL single_count: frames_sent=%0d want 1", frames_sent);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int re0;
        do_reset();
        push(8'h01);
        push(8'h6A);
        re0 = re_cnt;
        Enable = 1'b1;
        run_frame(8'h01, 1'b1, -1, "b2b_01");
        first_done = last_done_cyc;
        run_frame(8'h6A, 1'b0, -1, "b2b_6A");
        total++;
        if (last_done_cyc - first_done !== 25) begin
            bad++;
            $display("FAIL b2b_spacing: %0d cycles want 25", last_done_cyc - first_done);
        end
        repeat (3) @(negedge clk);
        total++;
        if (re_cnt - re0 !== 2 || frames_sent !== 16'd2) begin
            bad++;
            $display("FAIL b2b_counts: reads=%0d frames_sent=%0d want 2 2", re_cnt - re0, frames_sent);
        end
    endtask

    task automatic test_enable_drop();
        push(8'hFF);
        push(8'h17);
        Enable = 1'b1;
        run_frame(8'hFF, 1'b0, 6, "endrop_FF");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (read_enable !== 1'b0 || tx_busy !== 1'b0 || serial_out !== 1'b1) begin
                bad++;
                $display("FAIL endrop_hold%0d: re=%b busy=%b so=%b want 0 0 1",
                         i, read_enable, tx_busy, serial_out);
            end
        end
        total++;
        if (frames_sent !== 16'd3) begin
            bad++;
            $display("FAIL endrop_count1: frames_sent=%0d want 3", frames_sent);
        end
        Enable = 1'b1;
        run_frame(8'h17, 1'b0, -1, "endrop_17");
        total++;
        if (frames_sent !== 16'd4) begin
            bad++;
            $display("FAIL endrop_count2: frames_sent=%0d want 4", frames_sent);
        end
    endtask

    task automatic test_midframe_reset();
        logic exp [0:5];
        exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        push(8'hB8);
        @(negedge clk);
        total++;
        if (read_enable !== 1'b1) begin
            bad++;
            $display("FAIL abort_read: read_enable=%b want 1", read_enable);
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (serial_out !== exp[i]) begin
                bad++;
                $display("FAIL abort_bit%0d: serial_out=%b want %b", i, serial_out, exp[i]);
            end
        end
        Reset = 1'b1;
        @(negedge clk);
        total++;
        if (serial_out !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0 || frames_sent !== 16'd0) begin
            bad++;
            $display("FAIL abort_reset: so=%b busy=%b done=%b cnt=%0d want 1 0 0 0",
                     serial_out, tx_busy, frame_done, frames_sent);
        end
        Reset = 1'b0;
        Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (frame_done !== 1'b0 || tx_busy !== 1'b0 || serial_out !== 1'b1) begin
                bad++;
                $display("FAIL abort_idle%0d: done=%b busy=%b so=%b want 0 0 1",
                         i, frame_done, tx_busy, serial_out);
            end
        end
        push(8'h3C);
        Enable = 1'b1;
        run_frame(8'h3C, 1'b0, -1, "abort_next_3C");
        total++;
        if (frames_sent !== 16'd1) begin
            bad++;
            $display("FAIL abort_count: frames_sent=%0d want 1", frames_sent);
        end
    endtask

    task automatic test_flow_control();
        Enable = 1'b1;
        sink_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (read_enable !== 1'b0 || serial_out !== 1'b1) begin
                bad++;
                $display("FAIL empty_hold%0d: re=%b so=%b want 0 1", i, read_enable, serial_out);
            end
        end
        sink_ready = 1'b0;
        push(8'h5A);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (read_enable !== 1'b0 || serial_out !== 1'b1) begin
                bad++;
                $display("FAIL sink_hold%0d: re=%b so=%b want 0 1", i, read_enable, serial_out);
            end
        end
        sink_ready = 1'b1;
        run_frame(8'h5A, 1'b0, -1, "sink_5A");
        total++;
        if (frames_sent !== 16'd2) begin
            bad++;
            $display("FAIL sink_count: frames_sent=%0d want 2", frames_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_midframe_reset();
        test_flow_control();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
